prog_delay_line: RTL

//  Runtime-programmable delay line for sample/valid streams in the capture path.

---
 rtl/prog_delay_line_pkg.sv | 41 ++++
 rtl/prog_delay_line_ram.sv | 59 +++++
 rtl/prog_delay_line.sv | 136 +++++++++++++
 3 files changed

// File: rtl/prog_delay_line_pkg.sv
// -----------------------------------------------------------------------------
// prog_delay_line_pkg
//   Shared definitions for the programmable delay line:
//   - FSM state encodings (ST_FILL / ST_RUN)
//   - clog2 constant function for deriving address widths
//   - clampDelay helper that limits a requested delay to 1..maxDelay
// -----------------------------------------------------------------------------
package prog_delay_line_pkg;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 32'sd0;
    remain = value - 32'sd1;
    while (remain > 32'sd0) begin
      result = result + 32'sd1;
      remain = remain >>> 1;
    end
    return result;
  endfunction

  // Delays are handled at a fixed 16-bit width here; callers truncate the
  // result back to their own delay width (the result never exceeds maxDelay).
  function automatic logic [15:0] clampDelay(input logic [15:0] request,
                                             input logic [15:0] maxDelay);
    logic [15:0] result;
    if (request == 16'd0) begin
      result = 16'd1;
    end else if (request > maxDelay) begin
      result = maxDelay;
    end else begin
      result = request;
    end
    return result;
  endfunction

endpackage

// File: rtl/prog_delay_line_ram.sv
// -----------------------------------------------------------------------------
// prog_delay_line_ram
//   Simple dual-port RAM, DEPTH x DATA_W, one write port and one synchronously
//   read port. The storage array has no reset so it maps onto block or
//   distributed RAM; only the read-data register is reset.
//   A read of the address being written in the same cycle returns the new
//   data, which is what lets a delay of 1 behave as a plain register stage.
// Ports:
//   clock   in  1       rising-edge clock
//   reset_n in  1       asynchronous active-low reset (read register only)
//   wrEn    in  1       write strobe
//   wrAddr  in  AW      write address
//   wrData  in  DATA_W  write data
//   rdEn    in  1       read strobe; read register holds when low
//   rdAddr  in  AW      read address
//   rdData  out DATA_W  registered read data
// -----------------------------------------------------------------------------
module prog_delay_line_ram #(
  parameter int DATA_W = 33,
  parameter int AW     = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [AW-1:0]     rdAddr,
  output logic [DATA_W-1:0] rdData
);

  localparam int DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdData_r;

  // Write port: no reset on the array.
  always_ff @(posedge clock) begin
    if (wrEn) begin
      mem_r[wrAddr] <= wrData;
    end
  end

  // Synchronous read port with write-through on address collision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdData_r <= DATA_W'(1'b0);
    end else if (rdEn) begin
      if (wrEn && (wrAddr == rdAddr)) begin
        rdData_r <= wrData;
      end else begin
        rdData_r <= mem_r[rdAddr];
      end
    end
  end

  assign rdData = rdData_r;

endmodule

// File: rtl/prog_delay_line.sv
// -----------------------------------------------------------------------------
// prog_delay_line
//   Runtime-programmable delay line for {validIn,dataIn}. Samples are written
//   into a circular RAM on every tick (ce=1) and read back curDelay ticks
//   later. After reset, flush or a delay change the line refills (FILL) and
//   validOut is suppressed until curDelay fresh ticks have passed.
// Ports:
//   clock    in  1      rising-edge clock
//   reset_n  in  1      asynchronous active-low reset
//   ce       in  1      tick enable; low freezes pointer, counter and outputs
//   flush    in  1      synchronous clear: pointer to 0, refill, delay kept
//   setDelay in  1      load delayIn (clamped to 1..MAX_DELAY) and refill
//   delayIn  in  DW     requested delay in ticks
//   validIn  in  1      input sample valid
//   dataIn   in  WIDTH  input sample
//   validOut out 1      delayed valid, forced low while filling
//   dataOut  out WIDTH  delayed sample
//   curDelay out DW     delay in force
//   filling  out 1      high in FILL state
// -----------------------------------------------------------------------------
module prog_delay_line
  import prog_delay_line_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DELAY  = 64,
  parameter int INIT_DELAY = 3,
  parameter int DW         = clog2(MAX_DELAY) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             flush,
  input  logic             setDelay,
  input  logic [DW-1:0]    delayIn,
  input  logic             validIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic             validOut,
  output logic [WIDTH-1:0] dataOut,
  output logic [DW-1:0]    curDelay,
  output logic             filling
);

  localparam int AW = DW - 1;

  localparam logic [AW-1:0] PTR_ZERO     = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE      = AW'(1'b1);
  localparam logic [DW-1:0] DLY_ZERO     = DW'(1'b0);
  localparam logic [DW-1:0] DLY_ONE      = DW'(1'b1);
  localparam logic [DW-1:0] DLY_INIT     = DW'(INIT_DELAY);
  localparam logic [15:0]   MAX_DELAY_16 = 16'(MAX_DELAY);

  logic [AW-1:0]  wrPtr_r;
  logic [DW-1:0]  curDelay_r;
  logic [DW-1:0]  fillCnt_r;
  logic [0:0]     state_r;
  logic           wrEn_s;
  logic [AW-1:0]  rdAddr_s;
  logic [WIDTH:0] rdData_s;

  // Write enable and read address. Reading wrPtr-D+1 with a registered read
  // gives exactly D ticks from write to output; D=MAX_DELAY wraps to wrPtr+1.
  always_comb begin
    wrEn_s   = ce & ~flush;
    rdAddr_s = wrPtr_r - curDelay_r[AW-1:0] + PTR_ONE;
  end

  // Write pointer: cleared by flush, otherwise advances once per tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_r <= PTR_ZERO;
    end else if (flush) begin
      wrPtr_r <= PTR_ZERO;
    end else if (ce) begin
      wrPtr_r <= wrPtr_r + PTR_ONE;
    end
  end

  // Delay register: loads the clamped request regardless of ce or flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      curDelay_r <= DLY_INIT;
    end else if (setDelay) begin
      curDelay_r <= DW'(clampDelay(16'(delayIn), MAX_DELAY_16));
    end
  end

  // Fill/run state machine: FILL lasts curDelay ticks after any restart.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_FILL;
      fillCnt_r <= DLY_ZERO;
    end else if (flush || setDelay) begin
      state_r   <= ST_FILL;
      fillCnt_r <= DLY_ZERO;
    end else if (ce) begin
      case (state_r)
        ST_FILL: begin
          if (fillCnt_r == (curDelay_r - DLY_ONE)) begin
            state_r <= ST_RUN;
          end else begin
            fillCnt_r <= fillCnt_r + DLY_ONE;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r   <= ST_FILL;
          fillCnt_r <= DLY_ZERO;
        end
      endcase
    end
  end

  prog_delay_line_ram #(
    .DATA_W (WIDTH + 1),
    .AW     (AW)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .wrEn    (wrEn_s),
    .wrAddr  (wrPtr_r),
    .wrData  ({validIn, dataIn}),
    .rdEn    (ce),
    .rdAddr  (rdAddr_s),
    .rdData  (rdData_s)
  );

  // The RAM read register is the output data register; valid is qualified
  // by the registered state so stale samples never surface while filling.
  assign dataOut  = rdData_s[WIDTH-1:0];
  assign validOut = rdData_s[WIDTH] & (state_r == ST_RUN);
  assign filling  = (state_r == ST_FILL);
  assign curDelay = curDelay_r;

endmodule
